// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet scheduler feeding bytes from NUM_REQ sources into one MMIO UART slot.
// Bus outputs are registered: the action chosen in a state appears on the bus the following cycle.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int DVSR_INIT = 53,
   parameter int MAX_PKT   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [10:0]          cfg_dvsr,
   input  logic                 cfg_dvsr_we,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 cs,
   output logic                 read,
   output logic                 write,
   output logic [4:0]           addr,
   output logic [31:0]          wr_data,
   input  logic [31:0]          rd_data
);
   localparam int CNT_W = $clog2(MAX_PKT + 2);
   typedef enum logic [2:0] {INIT, IDLE, CHECK, SEND, GAP} state_t;
   state_t state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d, rr_q, rr_d, pick;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic last_q, last_d, pend_q, pend_d, wr_q, wr_d, busy_q, found;
   logic [10:0] dvsr_q, dvsr_d;
   logic [4:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [NUM_REQ-1:0] ready_q, ready_d, gmask;
   logic [7:0] byte_g;
   logic valid_g, last_g, unused_ok;
   assign gmask = NUM_REQ'(1) << grant_q;
   assign valid_g = |(req_valid & gmask);
   assign last_g = |(req_last & gmask);
   assign byte_g = 8'(req_data >> {grant_q, 3'b000});
   assign unused_ok = ^{rd_data[31:10], rd_data[8:0]};
   // first valid requester after the rr pointer, with wrap-around
   always_comb begin
      found = 1'b0;
      pick = rr_q;
      for (int k = 1; k <= NUM_REQ; k++)
         for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_valid[i] && (int'(rr_q) + k) % NUM_REQ == i) begin
               found = 1'b1;
               pick = ID_W'(i);
            end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d = rr_q;
      cnt_d = cnt_q;
      last_d = last_q;
      pend_d = pend_q;
      dvsr_d = dvsr_q;
      wr_d = 1'b0;
      addr_d = '0;
      data_d = '0;
      ready_d = '0;
      case (state_q)
         INIT: begin
            wr_d = 1'b1;
            addr_d = 5'd1;
            data_d = {21'h0, 11'(DVSR_INIT)};
            state_d = IDLE;
         end
         IDLE:
            if (pend_q) begin
               wr_d = 1'b1;
               addr_d = 5'd1;
               data_d = {21'h0, dvsr_q};
               pend_d = 1'b0;
            end else if (found) begin
               grant_d = pick;
               rr_d = pick;
               cnt_d = '0;
               state_d = CHECK;
            end
         CHECK: state_d = (!rd_data[9] && valid_g) ? SEND : CHECK;
         SEND: begin
            wr_d = 1'b1;
            addr_d = 5'd2;
            data_d = {24'h0, byte_g};
            ready_d = gmask;
            cnt_d = cnt_q + CNT_W'(1);
            last_d = last_g;
            state_d = GAP;
         end
         GAP: state_d = (last_q || (MAX_PKT != 0 && cnt_q == CNT_W'(MAX_PKT))) ? IDLE : CHECK;
         default: state_d = INIT;
      endcase
      // a write landing on the apply cycle stays pending for the next IDLE cycle
      if (cfg_dvsr_we) begin
         pend_d = 1'b1;
         dvsr_d = cfg_dvsr;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         grant_q <= '0;
         rr_q <= ID_W'(NUM_REQ - 1);
         cnt_q <= '0;
         last_q <= 1'b0;
         pend_q <= 1'b0;
         dvsr_q <= 11'(DVSR_INIT);
         wr_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ready_q <= '0;
         busy_q <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q <= rr_d;
         cnt_q <= cnt_d;
         last_q <= last_d;
         pend_q <= pend_d;
         dvsr_q <= dvsr_d;
         wr_q <= wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
         ready_q <= ready_d;
         busy_q <= state_d != IDLE;
      end
   end
   assign cs = wr_q;
   assign write = wr_q;
   assign read = 1'b0;
   assign addr = addr_q;
   assign wr_data = data_q;
   assign req_ready = ready_q;
   assign busy = busy_q;
   assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, timed corner sequences and randomized packets against a queue-level model.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic [N-1:0] req_valid, req_last, req_ready;
   logic [8*N-1:0] req_data;
   logic [10:0] cfg_dvsr;
   logic cfg_dvsr_we, busy, cs, read, write;
   logic [1:0] grant_id;
   logic [4:0] addr;
   logic [31:0] wr_data, rd_data;
   uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .DVSR_INIT(53), .MAX_PKT(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .cfg_dvsr(cfg_dvsr), .cfg_dvsr_we(cfg_dvsr_we), .busy(busy),
      .grant_id(grant_id), .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
      .rd_data(rd_data)
   );
   typedef struct {logic [4:0] a; logic [31:0] d; logic [1:0] g; int c;} ev_t;
   typedef struct {logic [3:0] mask; int npk; logic [31:0] order; int n;} vec_t;
   ev_t log_q[$];
   logic [8:0] rq[N][$];
   logic [8:0] mq[N][$];
   logic [9:0] expq[$];
   vec_t vt[5];
   int n_chk = 0, n_fail = 0, cyc = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = rq[i].size() != 0;
         req_last[i] = req_valid[i] ? rq[i][0][8] : 1'b0;
         req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'h0;
      end
   endtask
   function automatic bit any_q();
      bit r = 0;
      for (int i = 0; i < N; i++) r |= rq[i].size() != 0;
      return r;
   endfunction
   task automatic step();
      @(negedge clk);
      cyc++;
      if (!reset) begin
         chk("read_low", 32'(read), 0);
         chk("cs_write", 32'(cs), 32'(write));
         if (!cs) begin
            chk("idle_addr", 32'(addr), 0);
            chk("idle_data", wr_data, 0);
         end else log_q.push_back('{addr, wr_data, grant_id, cyc});
         chk("ready_onehot", 32'(req_ready), (cs && addr == 5'd2) ? 32'(1 << grant_id) : 32'h0);
         for (int i = 0; i < N; i++) if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      end
      drive();
   endtask
   task automatic do_reset();
      reset = 1'b1;
      rd_data = 32'h100;
      cfg_dvsr_we = 1'b0;
      cfg_dvsr = '0;
      for (int i = 0; i < N; i++) rq[i].delete();
      drive();
      step();
      step();
      chk("rst_cs", 32'(cs), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_ready", 32'(req_ready), 0);
      reset = 1'b0;
      step();
      chk("init_cs", 32'(cs), 1);
      chk("init_addr", 32'(addr), 1);
      chk("init_data", wr_data, 53);
      step();
      chk("post_init_busy", 32'(busy), 0);
      chk("post_init_cs", 32'(cs), 0);
      log_q.delete();
   endtask
   task automatic run_idle(input int maxc, input string nm, input bit rand_full);
      int k = 0;
      while ((any_q() || busy) && k < maxc) begin
         if (rand_full) rd_data[9] = $urandom_range(0, 3) == 0;
         step();
         k++;
      end
      rd_data[9] = 1'b0;
      chk({nm, "_timeout"}, 32'(k < maxc), 1);
   endtask
   task automatic wait_writes(input int n, input string nm);
      int k = 0;
      while (log_q.size() < n && k < 50) begin
         step();
         k++;
      end
      chk({nm, "_wait"}, 32'(log_q.size() >= n), 1);
   endtask
   initial begin
      logic [31:0] ord;
      int ea[8], ed[8], eg[8];
      vt[0] = '{4'b1011, 2, 32'h00310310, 6};
      vt[1] = '{4'b0110, 1, 32'h00000021, 2};
      vt[2] = '{4'b1000, 2, 32'h00000033, 2};
      vt[3] = '{4'b1111, 1, 32'h00003210, 4};
      vt[4] = '{4'b0101, 2, 32'h00002020, 4};
      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int i = 0; i < N; i++)
            for (int p = 0; p < vt[v].npk; p++) if (vt[v].mask[i]) rq[i].push_back({1'b1, 4'(i), 4'(p)});
         drive();
         run_idle(300, "vec", 0);
         chk("vec_count", log_q.size(), vt[v].n);
         ord = vt[v].order;
         for (int k = 0; k < log_q.size() && k < vt[v].n; k++) begin
            chk("vec_grant", 32'(log_q[k].g), 32'(ord[4*k +: 4]));
            chk("vec_src", 32'(log_q[k].d[7:4]), 32'(ord[4*k +: 4]));
         end
      end
      // three bytes from requester 2: one write every third cycle, busy falls after the last gap
      do_reset();
      rq[2].push_back(9'h041);
      rq[2].push_back(9'h042);
      rq[2].push_back(9'h143);
      drive();
      for (int c = 1; c <= 10; c++) begin
         step();
         chk("a_cs", 32'(cs), 32'(c % 3 == 0));
         if (c % 3 == 0) begin
            chk("a_addr", 32'(addr), 2);
            chk("a_data", wr_data, 32'h40 + 32'(c / 3));
         end
         chk("a_busy", 32'(busy), 32'(c < 10));
         chk("a_grant", 32'(grant_id), 2);
      end
      // tx_full held for 10 cycles after the first byte
      do_reset();
      for (int b = 0; b < 4; b++) rq[0].push_back({b == 3, 8'h51 + 8'(b)});
      drive();
      wait_writes(1, "b");
      rd_data[9] = 1'b1;
      repeat (10) step();
      rd_data[9] = 1'b0;
      run_idle(100, "b", 0);
      chk("b_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         for (int k = 0; k < 4; k++) chk("b_data", log_q[k].d, 32'h51 + 32'(k));
         chk("b_resume", log_q[1].c - log_q[0].c, 12);
         chk("b_pace", log_q[2].c - log_q[1].c, 3);
      end
      // divisor update mid-packet is deferred until the packet ends, ahead of the next grant
      do_reset();
      for (int b = 0; b < 4; b++) rq[1].push_back({b == 3, 8'h61 + 8'(b)});
      drive();
      wait_writes(1, "c");
      cfg_dvsr = 11'h145;
      cfg_dvsr_we = 1'b1;
      step();
      cfg_dvsr_we = 1'b0;
      rq[3].push_back(9'h171);
      drive();
      run_idle(100, "c", 0);
      ea = '{2, 2, 2, 2, 1, 2, 0, 0};
      ed = '{'h61, 'h62, 'h63, 'h64, 'h145, 'h71, 0, 0};
      chk("c_count", log_q.size(), 6);
      for (int k = 0; k < 6 && k < log_q.size(); k++) begin
         chk("c_addr", 32'(log_q[k].a), 32'(ea[k]));
         chk("c_data", log_q[k].d, 32'(ed[k]));
      end
      // forced release after four bytes lets requester 2 in before bytes 5-6
      do_reset();
      for (int b = 0; b < 6; b++) rq[1].push_back({b == 5, 8'h11 + 8'(b)});
      rq[2].push_back(9'h021);
      rq[2].push_back(9'h122);
      drive();
      run_idle(200, "d", 0);
      eg = '{1, 1, 1, 1, 2, 2, 1, 1};
      ed = '{'h11, 'h12, 'h13, 'h14, 'h21, 'h22, 'h15, 'h16};
      chk("d_count", log_q.size(), 8);
      for (int k = 0; k < 8 && k < log_q.size(); k++) begin
         chk("d_grant", 32'(log_q[k].g), 32'(eg[k]));
         chk("d_data", log_q[k].d, 32'(ed[k]));
      end
      // random packets with random tx_full, against a packet-level round-robin model
      for (int r = 0; r < 3; r++) begin
         int rr, pick, cnt, np;
         bit done;
         logic [8:0] b;
         do_reset();
         expq.delete();
         for (int i = 0; i < N; i++) begin
            mq[i].delete();
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
               int len = $urandom_range(1, 6);
               for (int j = 0; j < len; j++) begin
                  b = {j == len - 1, 8'($urandom)};
                  rq[i].push_back(b);
                  mq[i].push_back(b);
               end
            end
         end
         rr = N - 1;
         forever begin
            pick = -1;
            for (int k = 1; k <= N; k++) if (pick < 0 && mq[(rr + k) % N].size() != 0) pick = (rr + k) % N;
            if (pick < 0) break;
            rr = pick;
            cnt = 0;
            done = 0;
            while (!done) begin
               b = mq[pick].pop_front();
               expq.push_back({2'(pick), b[7:0]});
               cnt++;
               done = b[8] || cnt == 4;
            end
         end
         drive();
         run_idle(6000, "rnd", 1);
         chk("rnd_count", log_q.size(), expq.size());
         for (int k = 0; k < log_q.size() && k < expq.size(); k++) begin
            chk("rnd_addr", 32'(log_q[k].a), 2);
            chk("rnd_byte", 32'({log_q[k].g, log_q[k].d[7:0]}), 32'(expq[k]));
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one MMIO UART slot among NUM_REQ hardware byte-stream sources.
- Drives the UART slot bus as a bus master. After reset it programs the baud divisor, then moves packets (byte streams terminated by a last flag) into the UART TX FIFO, pacing on the tx_full status bit.
- Grant is held for a whole packet, so one packet's bytes are never interleaved with another's.
- Sits between on-chip message sources (debug/trace/status emitters) and the UART slot, in place of a CPU driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.
- DVSR_INIT, 53, 11-bit divisor written after reset (115200 baud at 100 MHz).
- MAX_PKT, 64, maximum bytes per grant before forced release; 0 disables the limit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its packet
- req_ready  out  NUM_REQ  one-hot pulse: byte accepted this cycle
- cfg_dvsr  in  11  new baud divisor
- cfg_dvsr_we  in  1  pulse; latches cfg_dvsr as a pending update
- busy  out  1  high when not in IDLE
- grant_id  out  ID_W  index of the current or most recent grantee
- cs  out  1  slot chip select
- read  out  1  slot read strobe; tied 0 (status is read combinationally)
- write  out  1  slot write strobe
- addr  out  5  slot address
- wr_data  out  32  slot write data
- rd_data  in  32  slot status; bit 9 = tx_full, bit 8 = rx_empty (combinational)

Behaviour:
- Slot map: addr 1 = divisor write (wr_data[10:0]); addr 2 = push TX byte (wr_data[7:0]).
- Every slot write is a single-cycle pulse with cs=write=1. Idle bus is cs=write=0, addr=0, wr_data=0.
- Reset values (registered): all slot outputs 0, req_ready=0, busy=1, grant_id=0.
- Reset also sets: rr pointer to NUM_REQ-1, pending-divisor flag clear, byte counter 0, state INIT.
- State INIT (1 cycle): write DVSR_INIT to addr 1; go to IDLE.
- State IDLE:
  - If a divisor update is pending: write it to addr 1, clear the flag, stay in IDLE. This takes priority over arbitration.
  - Else if any req_valid: grant the first valid index searching from rr+1 with wrap-around; set grant_id and rr to that index; clear the byte counter; go to CHECK.
- State CHECK:
  - If rd_data[9]=1: hold in CHECK.
  - Else if req_valid[grant_id]=1: go to SEND.
  - Else: hold; the grant is kept, and a stalled requester blocks the others.
- State SEND (1 cycle):
  - Slot write to addr 2 with wr_data = {24'h0, granted byte}.
  - req_ready[grant_id]=1 in the same cycle; the byte is consumed here.
  - Increment the byte counter; go to GAP.
- State GAP (1 cycle): no bus activity, which gives the FIFO full flag time to update. Then:
  - If the sent byte had req_last=1: go to IDLE.
  - Else if MAX_PKT!=0 and the counter equals MAX_PKT: forced release to IDLE. The requester's remaining bytes form a new packet on its next grant.
  - Else: go to CHECK.
- Throughput: at most 1 byte per 3 clocks (CHECK, SEND, GAP).
- Grant-to-first-write latency: 2 cycles when not full (IDLE→CHECK→SEND).
- req_ready is never asserted to a non-granted requester, and never two bits at once.
- cfg_dvsr_we at any time latches cfg_dvsr and sets the pending flag; a later pulse overwrites the value. Pending updates are applied only in IDLE, never mid-packet.
- Simultaneous cfg_dvsr_we and the IDLE apply cycle: the new value stays pending and is applied on the next IDLE cycle.
- req_data and req_last must be stable while req_valid=1 and not yet accepted. Deasserting req_valid mid-packet is legal (CHECK waits).
- Reset mid-packet: the current byte is abandoned, INIT reruns, and the divisor returns to DVSR_INIT.

Test Plan:
- Reset, no requests → first cycle after reset: cs=1, write=1, addr=1, wr_data=53; then idle bus, busy=0.
- Req 2 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), rd_data=0 → writes to addr 2 occur every 3rd cycle in order; req_ready[2] pulses 3 times; busy falls after the final GAP.
- Reqs 0, 1, 3 each hold a 1-byte packet simultaneously, starting from reset → grant order 0, 1, 3, 0… with no interleaving.
- tx_full (rd_data[9]=1) for 10 cycles mid-packet → no addr 2 writes during those cycles; resumes 1 cycle after it clears, no byte lost or duplicated.
- cfg_dvsr_we with 0x145 during a 4-byte packet → addr 1 write of 0x145 occurs only after that packet's last byte, before the next grant.
- MAX_PKT=4, req 1 streams 6 bytes with req_last only on byte 6 while req 2 is valid → after 4 bytes req 2 is granted, then req 1 resumes with bytes 5–6.
